// File: rtl/ast_tensor_job_scheduler.sv
// Tensor job scheduler: arbitrates among NREQ requesters for one shared
// tensor system and runs each granted job end to end. It loads A and then B
// from the single-port scratchpad, starts the engine, waits for done, drains
// result X back to the scratchpad, and acknowledges the requester.
module ast_tensor_job_scheduler #(
  parameter int NREQ      = 4,
  parameter int SIZE      = 4,
  parameter int DATAWIDTH = 14,
  parameter int AW        = 8,
  localparam int DW       = $clog2(SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_a_base,
  input  logic [NREQ*AW-1:0]   req_b_base,
  input  logic [NREQ*AW-1:0]   req_x_base,
  input  logic [NREQ*DW-1:0]   req_a_depth,
  input  logic [NREQ*DW-1:0]   req_a_width,
  input  logic [NREQ*DW-1:0]   req_b_depth,
  input  logic [NREQ*DW-1:0]   req_b_width,
  input  logic [NREQ-1:0]      req_relu,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_ren,
  input  logic [DATAWIDTH-1:0] mem_rdata,
  output logic                 mem_wen,
  output logic [DATAWIDTH-1:0] mem_wdata,
  output logic [DW-1:0]        ts_depth,
  output logic [DW-1:0]        ts_width,
  output logic [DATAWIDTH-1:0] ts_data_in,
  output logic                 ts_wen,
  output logic                 ts_set,
  output logic                 ts_relu,
  output logic                 ts_start,
  output logic                 ts_ren,
  input  logic [DATAWIDTH-1:0] ts_data_out,
  input  logic                 ts_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 2 * DW;

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_DRAIN, S_ACK, S_REJECT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_gnt;
  logic [AW-1:0]   r_a_base, r_b_base, r_x_base;
  logic [DW-1:0]   r_a_depth, r_a_width, r_b_depth, r_b_width;
  logic            r_relu;
  logic [CW-1:0]   r_cnt;
  logic            r_rd_pend;   // a scratchpad read was issued last cycle
  logic            r_rd_set;    // matrix of that read (0 = A, 1 = B)

  logic            w_found;
  logic [PW-1:0]   w_gnt;
  logic            w_bad;
  logic [CW-1:0]   w_na, w_nb, w_nr;

  // Per-requester views of the packed descriptor buses
  logic [AW-1:0] w_a_base_arr  [NREQ];
  logic [AW-1:0] w_b_base_arr  [NREQ];
  logic [AW-1:0] w_x_base_arr  [NREQ];
  logic [DW-1:0] w_a_depth_arr [NREQ];
  logic [DW-1:0] w_a_width_arr [NREQ];
  logic [DW-1:0] w_b_depth_arr [NREQ];
  logic [DW-1:0] w_b_width_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_a_base_arr[g]  = req_a_base[g*AW +: AW];
    assign w_b_base_arr[g]  = req_b_base[g*AW +: AW];
    assign w_x_base_arr[g]  = req_x_base[g*AW +: AW];
    assign w_a_depth_arr[g] = req_a_depth[g*DW +: DW];
    assign w_a_width_arr[g] = req_a_width[g*DW +: DW];
    assign w_b_depth_arr[g] = req_b_depth[g*DW +: DW];
    assign w_b_width_arr[g] = req_b_width[g*DW +: DW];
  end

  function automatic logic dim_bad(input logic [DW-1:0] d);
    return (d == '0) || (d > DW'(SIZE));
  endfunction

  // Word counts of the latched job: A words, B words, result words
  assign w_na = CW'(r_a_depth) * CW'(r_a_width);
  assign w_nb = CW'(r_b_depth) * CW'(r_b_width);
  assign w_nr = CW'(r_a_width) * CW'(r_b_depth);

  // Round-robin search: first requesting index after the pointer, wrapping
  always_comb begin : arb_comb
    logic [PW-1:0] cand;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    cand    = '0;
    w_found = 1'b0;
    w_gnt   = r_ptr;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req[cand]) begin
        w_found = 1'b1;
        w_gnt   = cand;
      end
    end
  end

  assign w_bad = dim_bad(w_a_depth_arr[w_gnt]) || dim_bad(w_a_width_arr[w_gnt]) ||
                 dim_bad(w_b_depth_arr[w_gnt]) || dim_bad(w_b_width_arr[w_gnt]);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (|req) w_next = S_ARB;
      S_ARB: begin
        if (!w_found)   w_next = S_IDLE;
        else if (w_bad) w_next = S_REJECT;
        else            w_next = S_LOAD_A;
      end
      S_LOAD_A: if (r_cnt == w_na - CW'(1)) w_next = S_LOAD_B;
      // One extra cycle after the last B read lets its write land
      S_LOAD_B: if (r_cnt == w_nb) w_next = S_START;
      S_START:  w_next = S_WAIT;
      S_WAIT:   if (ts_done) w_next = S_DRAIN;
      // N reads plus one cycle for the trailing write
      S_DRAIN:  if (r_cnt == w_nr) w_next = S_ACK;
      S_ACK:    w_next = S_IDLE;
      S_REJECT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Grant pointer and latched job descriptor, captured in ARB
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr     <= PW'(NREQ - 1);
      r_gnt     <= '0;
      r_a_base  <= '0;
      r_b_base  <= '0;
      r_x_base  <= '0;
      r_a_depth <= '0;
      r_a_width <= '0;
      r_b_depth <= '0;
      r_b_width <= '0;
      r_relu    <= 1'b0;
    end else if (r_state == S_ARB && w_found) begin
      r_ptr     <= w_gnt;
      r_gnt     <= w_gnt;
      r_a_base  <= w_a_base_arr[w_gnt];
      r_b_base  <= w_b_base_arr[w_gnt];
      r_x_base  <= w_x_base_arr[w_gnt];
      r_a_depth <= w_a_depth_arr[w_gnt];
      r_a_width <= w_a_width_arr[w_gnt];
      r_b_depth <= w_b_depth_arr[w_gnt];
      r_b_width <= w_b_width_arr[w_gnt];
      r_relu    <= req_relu[w_gnt];
    end
  end

  // Step counter (cleared on every state change) and read-pending pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_rd_pend <= 1'b0;
      r_rd_set  <= 1'b0;
    end else begin
      r_cnt     <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
      r_rd_pend <= mem_ren;
      r_rd_set  <= (r_state == S_LOAD_B);
    end
  end

  // Scratchpad side: reads during the loads, writes one cycle behind each ts_ren
  always_comb begin
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ts_ren    = 1'b0;
    unique case (r_state)
      S_LOAD_A: begin
        mem_ren  = 1'b1;
        mem_addr = r_a_base + AW'(r_cnt);
      end
      S_LOAD_B: begin
        if (r_cnt < w_nb) begin
          mem_ren  = 1'b1;
          mem_addr = r_b_base + AW'(r_cnt);
        end
      end
      S_DRAIN: begin
        ts_ren = (r_cnt < w_nr);
        if (r_cnt != '0) begin
          mem_wen   = 1'b1;
          mem_addr  = r_x_base + AW'(r_cnt - CW'(1));
          mem_wdata = ts_data_out;
        end
      end
      default: ;
    endcase
  end

  // Tensor load port follows the read pipeline; dims track the word's matrix
  always_comb begin
    ts_wen     = r_rd_pend;
    ts_set     = r_rd_pend & r_rd_set;
    ts_data_in = r_rd_pend ? mem_rdata : '0;
    ts_depth   = '0;
    ts_width   = '0;
    if (r_rd_pend) begin
      ts_depth = r_rd_set ? r_b_depth : r_a_depth;
      ts_width = r_rd_set ? r_b_width : r_a_width;
    end
  end

  // Control pulses and completion handshake
  always_comb begin
    ack      = '0;
    err      = (r_state == S_REJECT);
    ts_start = (r_state == S_START);
    ts_relu  = r_relu & ((r_state == S_WAIT) || (r_state == S_DRAIN));
    if (r_state == S_ACK || r_state == S_REJECT) ack[r_gnt] = 1'b1;
  end

endmodule

// File: tb/tb_ast_tensor_job_scheduler.sv
// Directed bench for ast_tensor_job_scheduler: a scratchpad responder returns
// 0x1000|addr one cycle after each read, a tensor responder returns an
// incrementing word after each ts_ren, and a negedge monitor logs activity.
module tb_ast_tensor_job_scheduler;

  localparam int NREQ = 4;
  localparam int SIZE = 4;
  localparam int DWID = 14;
  localparam int AW   = 8;
  localparam int DW   = 3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*AW-1:0]   req_a_base = '0, req_b_base = '0, req_x_base = '0;
  logic [NREQ*DW-1:0]   req_a_depth = '0, req_a_width = '0, req_b_depth = '0, req_b_width = '0;
  logic [NREQ-1:0]      req_relu = '0;
  logic [NREQ-1:0]      ack;
  logic                 err;
  logic [AW-1:0]        mem_addr;
  logic                 mem_ren;
  logic [DWID-1:0]      mem_rdata = '0;
  logic                 mem_wen;
  logic [DWID-1:0]      mem_wdata;
  logic [DW-1:0]        ts_depth, ts_width;
  logic [DWID-1:0]      ts_data_in;
  logic                 ts_wen, ts_set, ts_relu, ts_start, ts_ren;
  logic [DWID-1:0]      ts_data_out = '0;
  logic                 ts_done = 1'b0;

  ast_tensor_job_scheduler #(.NREQ(NREQ), .SIZE(SIZE), .DATAWIDTH(DWID), .AW(AW)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_a_base(req_a_base), .req_b_base(req_b_base), .req_x_base(req_x_base),
    .req_a_depth(req_a_depth), .req_a_width(req_a_width),
    .req_b_depth(req_b_depth), .req_b_width(req_b_width), .req_relu(req_relu),
    .ack(ack), .err(err), .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .ts_depth(ts_depth), .ts_width(ts_width),
    .ts_data_in(ts_data_in), .ts_wen(ts_wen), .ts_set(ts_set), .ts_relu(ts_relu),
    .ts_start(ts_start), .ts_ren(ts_ren), .ts_data_out(ts_data_out), .ts_done(ts_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            set;
    logic [DW-1:0]   depth;
    logic [DW-1:0]   width;
    logic [DWID-1:0] data;
    logic [31:0]     cyc;
  } wen_t;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [DWID-1:0] data;
  } wr_t;

  int              n_assert = 0;
  int              n_fail = 0;
  int              cyc = 0;
  int              overlap = 0;
  int              start_cnt = 0;
  logic [AW-1:0]   rd_q[$];
  wen_t            wen_q[$];
  wr_t             wr_q[$];
  logic [NREQ:0]   ack_q[$];
  logic [DWID-1:0] seq = 14'h0100;

  // Scratchpad and tensor responders (one-cycle read latency each)
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= 14'h1000 | DWID'(mem_addr);
    if (ts_ren) begin
      ts_data_out <= seq;
      seq         <= seq + 14'd1;
    end
  end

  // Activity monitor, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (mem_ren && mem_wen) overlap++;
    if (mem_ren) rd_q.push_back(mem_addr);
    if (ts_wen) wen_q.push_back({ts_set, ts_depth, ts_width, ts_data_in, 32'(cyc)});
    if (mem_wen) wr_q.push_back({mem_addr, mem_wdata});
    if (ack != '0) ack_q.push_back({err, ack});
    if (ts_start) start_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_out();
    return 64'({ack, err, mem_addr, mem_ren, mem_wen, mem_wdata, ts_depth, ts_width,
                ts_data_in, ts_wen, ts_set, ts_relu, ts_start, ts_ren});
  endfunction

  task automatic set_desc(input int i, input logic [AW-1:0] ab, bb, xb,
                          input logic [DW-1:0] ad, aw, bd, bw, input logic relu);
    req_a_base[i*AW +: AW]  = ab;
    req_b_base[i*AW +: AW]  = bb;
    req_x_base[i*AW +: AW]  = xb;
    req_a_depth[i*DW +: DW] = ad;
    req_a_width[i*DW +: DW] = aw;
    req_b_depth[i*DW +: DW] = bd;
    req_b_width[i*DW +: DW] = bw;
    req_relu[i]             = relu;
  endtask

  task automatic clear_logs();
    rd_q.delete();
    wen_q.delete();
    wr_q.delete();
  endtask

  // Returns one cycle into WAIT (the cycle after the ts_start pulse)
  task automatic wait_start(input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (ts_start) seen = 1'b1;
    end
    check({tag, "_start_seen"}, 64'(seen), 64'd1);
    step();
  endtask

  task automatic pulse_done();
    ts_done = 1'b1;
    step();
    ts_done = 1'b0;
  endtask

  // Returns at the negedge of the ack cycle with {err, ack}
  task automatic wait_ack(input string tag, output logic [NREQ:0] got);
    logic seen;
    seen = 1'b0;
    got  = '0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (ack != '0) begin
        seen = 1'b1;
        got  = {err, ack};
      end
    end
    check({tag, "_ack_seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    logic [NREQ:0]   got;
    int              s0, n0, r0, w0;
    logic [DWID-1:0] exp_d;
    logic [3:0]      rr_exp [4];
    logic            saw2;

    rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};

    // Reset state
    repeat (3) step();
    check("reset_outputs", all_out(), 64'd0);
    reset = 1'b0;
    step();
    check("idle_outputs", all_out(), 64'd0);

    // Single job on requester 0: A 2x2 @0x00, B 2x2 @0x10, X @0x20
    set_desc(0, 8'h00, 8'h10, 8'h20, 3'd2, 3'd2, 3'd2, 3'd2, 1'b1);
    clear_logs();
    s0 = start_cnt;
    req = 4'b0001;
    wait_start("job1");
    check("job1_wait_relu", 64'({ts_relu, ts_start, ack}), 64'({1'b1, 1'b0, 4'b0000}));
    pulse_done();
    wait_ack("job1", got);
    req = '0;
    check("job1_ack", 64'(got), 64'({1'b0, 4'b0001}));
    step();
    check("job1_ack_one_cycle", 64'({err, ack}), 64'd0);
    check("job1_start_count", 64'(start_cnt - s0), 64'd1);
    check("job1_wen_count", 64'(wen_q.size()), 64'd8);
    check("job1_rd_count", 64'(rd_q.size()), 64'd8);
    if (wen_q.size() == 8 && rd_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        exp_d = (i < 4) ? (14'h1000 + DWID'(i)) : (14'h1010 + DWID'(i - 4));
        check($sformatf("job1_rd%0d", i), 64'(rd_q[i]), 64'(exp_d[AW-1:0]));
        check($sformatf("job1_wen%0d", i),
              64'({wen_q[i].set, wen_q[i].depth, wen_q[i].width, wen_q[i].data}),
              64'({(i >= 4), 3'd2, 3'd2, exp_d}));
      end
      check("job1_wen_back_to_back", 64'(wen_q[7].cyc - wen_q[0].cyc), 64'd7);
    end
    check("job1_wr_count", 64'(wr_q.size()), 64'd4);
    if (wr_q.size() == 4)
      for (int k = 0; k < 4; k++)
        check($sformatf("job1_wr%0d", k), 64'(wr_q[k]),
              64'({8'h20 + 8'(k), 14'h0100 + DWID'(k)}));

    // Spurious ts_done during LOAD_B is ignored (requester 1)
    set_desc(1, 8'h30, 8'h38, 8'h50, 3'd2, 3'd2, 3'd2, 3'd2, 1'b0);
    clear_logs();
    s0 = start_cnt;
    req = 4'b0010;
    begin
      logic seen_b;
      seen_b = 1'b0;
      for (int n = 0; n < 100 && !seen_b; n++) begin
        @(negedge clk);
        if (ts_wen && ts_set) seen_b = 1'b1;
      end
      check("spur_in_load_b", 64'(seen_b), 64'd1);
    end
    ts_done = 1'b1;
    @(negedge clk);
    ts_done = 1'b0;
    check("spur_no_start_yet", 64'(start_cnt - s0), 64'd0);
    wait_start("spur");
    repeat (3) step();
    check("spur_still_waiting", 64'({ack, ts_ren, mem_wen}), 64'd0);
    pulse_done();
    wait_ack("spur", got);
    req = '0;
    check("spur_ack", 64'(got), 64'({1'b0, 4'b0010}));
    step();

    // Rejects on requester 2: a_width = 0, then a_depth = SIZE+1
    r0 = rd_q.size();
    w0 = wen_q.size();
    set_desc(2, 8'h00, 8'h00, 8'h00, 3'd2, 3'd0, 3'd2, 3'd2, 1'b0);
    req = 4'b0100;
    step();
    step();
    check("rej0_ack_err", 64'({err, ack}), 64'({1'b1, 4'b0100}));
    req = '0;
    step();
    check("rej0_one_cycle", 64'({err, ack}), 64'd0);
    set_desc(2, 8'h00, 8'h00, 8'h00, 3'd5, 3'd2, 3'd2, 3'd2, 1'b0);
    req = 4'b0100;
    step();
    step();
    check("rej5_ack_err", 64'({err, ack}), 64'({1'b1, 4'b0100}));
    req = '0;
    step();
    check("rej_no_activity", 64'({rd_q.size() - r0, wen_q.size() - w0}), 64'd0);

    // Address wrap on requester 3: A 2x2 @0xFE, B depth1 x width3 @0x40, X @0x60
    set_desc(3, 8'hFE, 8'h40, 8'h60, 3'd2, 3'd2, 3'd1, 3'd3, 1'b0);
    clear_logs();
    req = 4'b1000;
    wait_start("wrap");
    pulse_done();
    wait_ack("wrap", got);
    req = '0;
    check("wrap_ack", 64'(got), 64'({1'b0, 4'b1000}));
    step();
    check("wrap_rd_count", 64'(rd_q.size()), 64'd7);
    if (rd_q.size() == 7)
      check("wrap_rd_addrs", 64'({rd_q[0], rd_q[1], rd_q[2], rd_q[3], rd_q[4], rd_q[5], rd_q[6]}),
            64'({8'hFE, 8'hFF, 8'h00, 8'h01, 8'h40, 8'h41, 8'h42}));
    check("wrap_wen_count", 64'(wen_q.size()), 64'd7);
    if (wen_q.size() == 7)
      check("wrap_b_dims", 64'({wen_q[3].set, wen_q[3].depth, wen_q[3].width,
                                wen_q[4].set, wen_q[4].depth, wen_q[4].width}),
            64'({1'b0, 3'd2, 3'd2, 1'b1, 3'd1, 3'd3}));
    check("wrap_wr_count", 64'(wr_q.size()), 64'd2);
    if (wr_q.size() == 2)
      check("wrap_wr_addrs", 64'({wr_q[0].addr, wr_q[1].addr}), 64'({8'h60, 8'h61}));

    // Round robin with req = 1011 held: grants 0, 1, 3, 0
    for (int i = 0; i < NREQ; i++)
      set_desc(i, 8'(8'h90 + 8'(i * 4)), 8'(8'hA0 + 8'(i * 4)), 8'(8'hB0 + 8'(i * 4)),
               3'd1, 3'd1, 3'd1, 3'd1, 1'b0);
    n0 = ack_q.size();
    req = 4'b1011;
    for (int j = 0; j < 4; j++) begin
      wait_start($sformatf("rr%0d", j));
      pulse_done();
      wait_ack($sformatf("rr%0d", j), got);
      check($sformatf("rr%0d_grant", j), 64'(got), 64'({1'b0, rr_exp[j]}));
    end
    req = '0;
    step();
    step();
    saw2 = 1'b0;
    for (int i = n0; i < ack_q.size(); i++) if (ack_q[i][2]) saw2 = 1'b1;
    check("rr_req2_never_acked", 64'(saw2), 64'd0);

    // Reset during WAIT, then requester 1 gets a full job
    set_desc(1, 8'h70, 8'h78, 8'h80, 3'd2, 3'd2, 3'd2, 3'd2, 1'b1);
    n0 = ack_q.size();
    req = 4'b0010;
    wait_start("rst1");
    check("rst_relu_in_wait", 64'(ts_relu), 64'd1);
    reset = 1'b1;
    step();
    check("rst_outputs_zero", all_out(), 64'd0);
    reset = 1'b0;
    wait_start("rst2");
    check("rst_no_ack", 64'(ack_q.size() - n0), 64'd0);
    pulse_done();
    wait_ack("rst2", got);
    req = '0;
    check("rst_job_ack", 64'(got), 64'({1'b0, 4'b0010}));
    step();

    check("port_exclusive", 64'(overlap), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
